// File: rtl/hdb3_pkg.sv
// Shared definitions for the HDB3 transmit chain: line symbols and sequencer states.
// Latency: n/a (package only).
// Backpressure: n/a.
package hdb3_pkg;

  // 2-bit symbols passed between encoder stages. The sequencer only emits
  // ZERO/ONE; B and V are introduced by the later stages.
  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_ONE  = 2'b01;
  localparam logic [1:0] SYM_B    = 2'b10;
  localparam logic [1:0] SYM_V    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FILL  = 2'd2,
    FLUSH = 2'd3
  } tx_state_e;

  // Map a data bit to its unipolar symbol.
  function automatic logic [1:0] bit_sym(input logic b);
    return b ? SYM_ONE : SYM_ZERO;
  endfunction

endpackage

// File: rtl/hdb3_tx_ctrl_if.sv
// Byte-in / symbol-out bundle between a message source and the HDB3 transmit sequencer.
// Latency: n/a (wires only).
// Backpressure: Tx_Valid/Tx_Ready handshake; encoder side is paced by Enc_Ce, no backpressure.
// Ports: master = byte source (drives Tx_*), slave = sequencer (drives Tx_Ready and encoder/status outputs).
interface hdb3_tx_ctrl_if;
  logic [7:0] Tx_Data;
  logic       Tx_Valid;
  logic       Tx_Last;
  logic       Tx_Ready;
  logic       Enc_Ce;
  logic [1:0] Enc_Data;
  logic       Line_Valid;
  logic       Busy;
  logic       Underrun;

  modport master (
    output Tx_Data, Tx_Valid, Tx_Last,
    input  Tx_Ready, Enc_Ce, Enc_Data, Line_Valid, Busy, Underrun
  );

  modport slave (
    input  Tx_Data, Tx_Valid, Tx_Last,
    output Tx_Ready, Enc_Ce, Enc_Data, Line_Valid, Busy, Underrun
  );
endinterface

// File: rtl/hdb3_bit_tick.sv
// Bit-rate divider: free-running 0..DIV-1 counter with synchronous clear and run gate.
// Latency: ce is registered and high for the one clock where the visible count is DIV-1.
// Backpressure: none; run=0 freezes the count.
// Ports: clk/rst_n, clr (zero the count next clock), run (advance), ce (bit strobe out).
module hdb3_bit_tick #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic ce
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ce_q, ce_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
    // Strobe is derived from the next count so it lines up with the count it describes.
    ce_d = (run || clr) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/hdb3_tx_ctrl.sv
// HDB3 transmit sequencer: serialises bytes MSB-first into unipolar symbols, paces the encoder chain, zero-fills and flushes.
// Latency: first symbol the clock after the handshake; Line_Valid follows PIPE_LAT bit periods later.
// Backpressure: Tx_Ready only in IDLE, in bit 7 of a non-last byte with the holding slot empty, and in FILL with the slot empty.
// Ports: Clk, Rst_n (async active-low); tx (slave modport) carries Tx_Data/Valid/Last/Ready, Enc_Ce, Enc_Data, Line_Valid, Busy, Underrun.
module hdb3_tx_ctrl
  import hdb3_pkg::*;
#(
  parameter int DIV      = 8,
  parameter int PIPE_LAT = 6
) (
  input  logic           Clk,
  input  logic           Rst_n,
  hdb3_tx_ctrl_if.slave  tx
);

  localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(PIPE_LAT - 1);

  tx_state_e             state_q, state_d;
  logic [7:0]            sh_q, sh_d;
  logic                  last_q, last_d;
  logic [2:0]            bitcnt_q, bitcnt_d;
  logic [7:0]            hold_q, hold_d;
  logic                  hold_last_q, hold_last_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [FW-1:0]         flush_cnt_q, flush_cnt_d;
  logic [PIPE_LAT-1:0]   vpipe_q, vpipe_d;
  logic                  tx_ready_q, tx_ready_d;
  logic [1:0]            enc_data_q, enc_data_d;
  logic                  underrun_q, underrun_d;

  logic                  enc_ce;
  logic                  tick_clr;
  logic                  acc;
  logic                  nxt_avail;
  logic [7:0]            nxt_dat;
  logic                  nxt_last;

  hdb3_bit_tick #(.DIV(DIV)) u_tick (
    .clk   (Clk),
    .rst_n (Rst_n),
    .clr   (tick_clr),
    .run   (state_q != IDLE),
    .ce    (enc_ce)
  );

  assign acc = tx.Tx_Valid && tx_ready_q;

  // Next byte to serialise: the holding slot if occupied, otherwise a byte
  // being accepted on this very clock (lets a late handshake still avoid a gap).
  assign nxt_avail = hold_vld_q || acc;
  assign nxt_dat   = hold_vld_q ? hold_q      : tx.Tx_Data;
  assign nxt_last  = hold_vld_q ? hold_last_q : tx.Tx_Last;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    last_d      = last_q;
    bitcnt_d    = bitcnt_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_vld_d  = hold_vld_q;
    flush_cnt_d = flush_cnt_q;
    vpipe_d     = vpipe_q;
    underrun_d  = 1'b0;
    tick_clr    = 1'b0;
    tx_ready_d  = 1'b0;
    enc_data_d  = SYM_ZERO;

    case (state_q)
      IDLE: begin
        if (acc) begin
          sh_d     = tx.Tx_Data;
          last_d   = tx.Tx_Last;
          bitcnt_d = 3'd0;
          tick_clr = 1'b1;
          state_d  = SHIFT;
        end
      end

      SHIFT, FILL: begin
        if (acc) begin
          hold_d      = tx.Tx_Data;
          hold_last_d = tx.Tx_Last;
          hold_vld_d  = 1'b1;
        end
        if (enc_ce) begin
          if (state_q == SHIFT && bitcnt_q != 3'd7) begin
            sh_d     = {sh_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + 3'd1;
          end else if (nxt_avail) begin
            sh_d       = nxt_dat;
            last_d     = nxt_last;
            bitcnt_d   = 3'd0;
            hold_vld_d = 1'b0;
            state_d    = SHIFT;
          end else if (state_q == SHIFT && last_q) begin
            flush_cnt_d = '0;
            state_d     = FLUSH;
          end else begin
            // Either the byte just ended with nothing queued, or another fill bit begins.
            underrun_d = 1'b1;
            state_d    = FILL;
          end
        end
      end

      FLUSH: begin
        if (enc_ce) begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_d = IDLE;
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Tags each bit entering the encoder; the MSB emerges with that bit at the line.
    if (enc_ce) begin
      vpipe_d = PIPE_LAT'({vpipe_q, (state_q == SHIFT) || (state_q == FILL)});
    end

    // Registered outputs are computed from next-state values so they change
    // on the same clock as the state they describe.
    case (state_d)
      IDLE:    tx_ready_d = 1'b1;
      SHIFT:   tx_ready_d = (bitcnt_d == 3'd7) && !last_d && !hold_vld_d;
      FILL:    tx_ready_d = !hold_vld_d;
      default: tx_ready_d = 1'b0;
    endcase

    if (state_d == SHIFT) begin
      enc_data_d = bit_sym(sh_d[7]);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      last_q      <= 1'b0;
      bitcnt_q    <= '0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      hold_vld_q  <= 1'b0;
      flush_cnt_q <= '0;
      vpipe_q     <= '0;
      tx_ready_q  <= 1'b0;
      enc_data_q  <= SYM_ZERO;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      last_q      <= last_d;
      bitcnt_q    <= bitcnt_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      hold_vld_q  <= hold_vld_d;
      flush_cnt_q <= flush_cnt_d;
      vpipe_q     <= vpipe_d;
      tx_ready_q  <= tx_ready_d;
      enc_data_q  <= enc_data_d;
      underrun_q  <= underrun_d;
    end
  end

  assign tx.Tx_Ready   = tx_ready_q;
  assign tx.Enc_Ce     = enc_ce;
  assign tx.Enc_Data   = enc_data_q;
  assign tx.Line_Valid = vpipe_q[PIPE_LAT-1];
  assign tx.Busy       = (state_q != IDLE) || vpipe_q[PIPE_LAT-1];
  assign tx.Underrun   = underrun_q;

endmodule

// File: tb/tb_hdb3_tx_ctrl.sv
// Directed bench for hdb3_tx_ctrl: DIV=4 main instance plus a DIV=2 instance for latency.
// Latency: n/a.
// Backpressure: bench source holds Tx_Valid until the handshake completes.
module tb_hdb3_tx_ctrl;
  import hdb3_pkg::*;

  logic clk;
  logic rst_n;

  hdb3_tx_ctrl_if tx();
  hdb3_tx_ctrl_if tx2();

  hdb3_tx_ctrl #(.DIV(4), .PIPE_LAT(6)) u_dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .tx    (tx)
  );

  hdb3_tx_ctrl #(.DIV(2), .PIPE_LAT(6)) u_dut2 (
    .Clk   (clk),
    .Rst_n (rst_n),
    .tx    (tx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int acc_cyc;
  int nlv, nur;

  logic [1:0] ed  [0:127];
  logic       lv  [0:127];
  logic       ce  [0:127];
  logic       ur  [0:127];
  logic       rdy [0:127];
  logic       bsy [0:127];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for Tx_Ready, then completes one handshake; returns in cycle 1 after it.
  task automatic start_byte(input logic [7:0] d, input logic l);
    int w;
    w = 0;
    while (!tx.Tx_Ready && w < 200) begin
      tick();
      w++;
    end
    chk("start_ready", tx.Tx_Ready, 1);
    tx.Tx_Data  = d;
    tx.Tx_Last  = l;
    tx.Tx_Valid = 1'b1;
    tick();
    tx.Tx_Valid = 1'b0;
  endtask

  // Records n cycles of outputs; optionally presents a second byte from cycle present_at.
  task automatic observe(input int n, input logic [7:0] d2, input logic l2, input int present_at);
    acc_cyc = 0;
    for (int c = 1; c <= n; c++) begin
      ed[c]  = tx.Enc_Data;
      lv[c]  = tx.Line_Valid;
      ce[c]  = tx.Enc_Ce;
      ur[c]  = tx.Underrun;
      rdy[c] = tx.Tx_Ready;
      bsy[c] = tx.Busy;
      if (c == present_at) begin
        tx.Tx_Data  = d2;
        tx.Tx_Last  = l2;
        tx.Tx_Valid = 1'b1;
      end
      if (tx.Tx_Valid && tx.Tx_Ready && acc_cyc == 0) acc_cyc = c;
      tick();
      if (acc_cyc == c) tx.Tx_Valid = 1'b0;
    end
    tx.Tx_Valid = 1'b0;
  endtask

  // Expected waveform for a message of nb bit periods (MSB of bits sent first), DIV=4, PIPE_LAT=6.
  task automatic chk_stream(input string tag, input logic [63:0] bits, input int nb, input int upto);
    for (int c = 1; c <= upto; c++) begin
      int   p;
      logic b;
      p = (c - 1) / 4;
      b = (p < nb) ? bits[nb-1-p] : 1'b0;
      chk($sformatf("%s_enc_data@%0d", tag, c), ed[c], b ? SYM_ONE : SYM_ZERO);
      chk($sformatf("%s_enc_ce@%0d", tag, c), ce[c], (c % 4 == 0) && (c <= 4 * (nb + 6)));
      chk($sformatf("%s_line_valid@%0d", tag, c), lv[c], (c >= 25) && (c <= 4 * nb + 24));
      chk($sformatf("%s_busy@%0d", tag, c), bsy[c], c <= 4 * nb + 24);
    end
  endtask

  task automatic tally(input int n);
    nlv = 0;
    nur = 0;
    for (int c = 1; c <= n; c++) begin
      nlv += int'(lv[c]);
      nur += int'(ur[c]);
    end
  endtask

  initial begin
    int w;
    int rise;
    int first_ce;

    rst_n = 1'b0;
    tx.Tx_Valid  = 1'b0; tx.Tx_Data  = '0; tx.Tx_Last  = 1'b0;
    tx2.Tx_Valid = 1'b0; tx2.Tx_Data = '0; tx2.Tx_Last = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_tx_ready",   tx.Tx_Ready,   0);
    chk("rst_enc_ce",     tx.Enc_Ce,     0);
    chk("rst_enc_data",   tx.Enc_Data,   0);
    chk("rst_line_valid", tx.Line_Valid, 0);
    chk("rst_busy",       tx.Busy,       0);
    chk("rst_underrun",   tx.Underrun,   0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready_before_clk", tx.Tx_Ready, 0);
    tick();
    chk("rel_ready_first_clk",  tx.Tx_Ready, 1);
    chk("rel_ready_first_clk2", tx2.Tx_Ready, 1);

    // Single byte 0xA5 with last
    start_byte(8'hA5, 1'b1);
    observe(64, 8'h00, 1'b0, 0);
    chk_stream("single", 64'hA5, 8, 64);
    tally(64);
    chk("single_lv_clocks", nlv, 32);
    chk("single_underruns", nur, 0);
    chk("single_ready_idle", rdy[57], 1);

    // Back-to-back 0xFF, 0x00(last); second byte held from cycle 1
    start_byte(8'hFF, 1'b0);
    observe(100, 8'h00, 1'b1, 1);
    chk("b2b_accept_cycle", acc_cyc, 29);
    chk("b2b_ready_bit6",   rdy[28], 0);
    chk("b2b_ready_bit7",   rdy[29], 1);
    chk_stream("b2b", 64'hFF00, 16, 100);
    tally(100);
    chk("b2b_lv_clocks", nlv, 64);
    chk("b2b_underruns", nur, 0);

    // Underrun: 0x81 then 0xC3(last) offered during the third fill bit
    start_byte(8'h81, 1'b0);
    observe(110, 8'hC3, 1'b1, 42);
    chk("fill_accept_cycle", acc_cyc, 42);
    chk_stream("fill", 64'({8'h81, 3'b000, 8'hC3}), 19, 110);
    tally(110);
    chk("fill_lv_clocks", nlv, 76);
    chk("fill_underruns", nur, 3);
    chk("fill_ur_1", ur[33], 1);
    chk("fill_ur_2", ur[37], 1);
    chk("fill_ur_3", ur[41], 1);

    // Reset in the middle of bit 3
    start_byte(8'h5A, 1'b0);
    repeat (13) tick();
    chk("mid_busy_before_rst", tx.Busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_ready",   tx.Tx_Ready,   0);
    chk("mid_rst_enc_ce",     tx.Enc_Ce,     0);
    chk("mid_rst_enc_data",   tx.Enc_Data,   0);
    chk("mid_rst_line_valid", tx.Line_Valid, 0);
    chk("mid_rst_busy",       tx.Busy,       0);
    chk("mid_rst_underrun",   tx.Underrun,   0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready_before_clk", tx.Tx_Ready, 0);
    tick();
    chk("mid_rel_ready_first_clk", tx.Tx_Ready, 1);
    start_byte(8'h3C, 1'b1);
    observe(64, 8'h00, 1'b0, 0);
    chk_stream("post_rst", 64'h3C, 8, 64);
    tally(64);
    chk("post_rst_underruns", nur, 0);

    // Tx_Valid held through FLUSH: taken on the first IDLE clock
    start_byte(8'h01, 1'b1);
    observe(70, 8'h77, 1'b1, 33);
    chk("flush_accept_cycle", acc_cyc, 57);
    chk("flush_ready_last",   rdy[56], 0);
    chk("flush_ready_idle",   rdy[57], 1);
    chk_stream("flush_hold", 64'h01, 8, 56);
    chk("next_bit7", ed[58], SYM_ZERO);
    chk("next_bit6", ed[62], SYM_ONE);
    w = 0;
    while (tx.Busy && w < 200) begin
      tick();
      w++;
    end
    chk("drain_busy", tx.Busy, 0);

    // DIV=2 latency
    chk("div2_ready", tx2.Tx_Ready, 1);
    tx2.Tx_Data  = 8'h80;
    tx2.Tx_Last  = 1'b1;
    tx2.Tx_Valid = 1'b1;
    tick();
    tx2.Tx_Valid = 1'b0;
    rise = 0;
    first_ce = 0;
    for (int c = 1; c <= 40; c++) begin
      if (tx2.Line_Valid && rise == 0) rise = c;
      if (tx2.Enc_Ce && first_ce == 0) first_ce = c;
      tick();
    end
    chk("div2_lv_rise",  rise, 13);
    chk("div2_first_ce", first_ce, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
